fir_seq_ctrl: RTL and testbench
===============================

// Module: fir_seq_ctrl
// PURPOSE
//  Scheduler for one FIR filter bank fed from a circular sample queue. Tracks the queue's write
//  pointer and fill level. On each new sample, once TAPS samples are held, asserts `sequencing`
//  for TAPS+2 cycles and walks `rd_ptr` oldest->newest, aligned to the filter's 1-cycle coeff ROM
//  and the queue's 1-cycle read latency. Pulses `smpl_done` when the filter outputs are valid.
// PARAMETERS
//  DEPTH   1536  queue entries
//  TAPS    1021  filter length; TAPS <= DEPTH
//  ADDR_W  11    pointer width; 2**ADDR_W >= DEPTH
// PORTS
//  clk        in   1       system clock
//  rst_n      in   1       asynchronous active-low reset
//  wrt_smpl   in   1       1-cycle pulse: a sample is written at new_ptr this cycle
//  flush      in   1       synchronous clear of pointers, fill count and any sequence
//  new_ptr    out  ADDR_W  queue write address
//  rd_ptr     out  ADDR_W  queue read address
//  sequencing out  1       drives filter `sequencing` input
//  smpl_done  out  1       1-cycle pulse: filter lft/rght outputs valid
//  full       out  1       fill count == TAPS
//  overrun    out  1       sticky: wrt_smpl arrived while a request could not be accepted
// BEHAVIOUR
//  - Reset (async) and flush (sync, highest priority after reset): new_ptr=0, rd_ptr=0,
//    fill=0, state IDLE, sequencing=0, smpl_done=0, full=0, overrun=0.
//  - All pointer arithmetic is modulo DEPTH; DEPTH-1 -> 0 on increment. No power-of-2 assumption.
//  - Every wrt_smpl, regardless of state: new_ptr <= new_ptr+1 (mod DEPTH).
//    fill <= min(fill+1, TAPS).
//  - Start: a wrt_smpl while full (registered, pre-increment) or after it fills (fill becomes
//    TAPS that cycle) captures old_ptr = W-(TAPS-1) mod DEPTH, W = address just written.
//    The next cycle enters SEQ.
//  - States IDLE -> SEQ -> DONE -> IDLE; cnt counts 0..TAPS+1 in SEQ.
//    SEQ: sequencing=1 for exactly TAPS+2 cycles (c=0..TAPS+1).
//      c=0: filter clears. rd_ptr don't-care; hold.
//      c=1..TAPS: rd_ptr = old_ptr+(c-1) mod DEPTH.
//      c=TAPS+1: rd_ptr holds.
//      Tap k is accumulated in cycle k+2, so the last tap lands in c=TAPS+1.
//    DONE: sequencing=0, smpl_done=1 for one cycle, then IDLE.
//  - Latency: start-of-SEQ to smpl_done = TAPS+2 cycles.
//  - wrt_smpl in SEQ/DONE: pointer and fill update as above; scheduling depends on the
//    optional feature below.
//  - wrt_smpl and flush in the same cycle: flush wins; sample is not counted.
//  - rst_n mid-SEQ: immediate abort. No smpl_done; fill restarts from 0.
// CONFIGURATION
//  FIR_SEQ_PENDING_EN defined:
//    - one-deep pending request; a wrt_smpl in SEQ/DONE sets pend.
//    - DONE goes straight back to SEQ with old_ptr recomputed from the newest written sample.
//    - a second wrt_smpl while pend=1 sets overrun.
//  FIR_SEQ_PENDING_EN undefined:
//    - a wrt_smpl in SEQ/DONE starts no sequence and sets overrun.
//  In both builds, overrun clears only on reset or flush.
// STRUCTURE
//  - Shared package eq_pkg: fir_seq_state_t enum {IDLE,SEQ,DONE}; constants TAPS_LP/TAPS_HP,
//    Q_DEPTH, Q_ADDR_W.
//  - Sub-module mod_inc (ADDR_W, DEPTH): combinational modulo increment/subtract-constant
//    helper, shared by the new_ptr and rd_ptr paths.
//  - cnt is $clog2(TAPS+2) bits.
// TESTING  (small build DEPTH=8 TAPS=5 unless noted)
//  - Reset: check the reset value of every output. 4 wrt_smpl -> new_ptr=4, full=0, no sequencing.
//  - 5th wrt_smpl (W=4) -> full=1, sequencing high 7 cycles, rd_ptr 0,1,2,3,4 at c=1..5,
//    smpl_done exactly 1 cycle after sequencing falls.
//  - Wrap: pulse until W=1 -> old_ptr=5, rd_ptr 5,6,7,0,1; new_ptr wraps 7->0.
//  - wrt_smpl at c=3:
//    - PENDING_EN: second SEQ starts right after DONE with old_ptr advanced by 1.
//    - otherwise: overrun=1, no second SEQ.
//  - flush at c=2: sequencing=0 next cycle, no smpl_done, fill=0, new_ptr=0, overrun cleared.
//  - Defaults with the real filter and a sample ROM model: impulse at the newest sample
//    -> lft_out = coeff[TAPS-1] scaled by >>15.

Source files
------------

// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared equaliser types and queue/filter sizing constants
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEQ  = 2'd1,
    DONE = 2'd2
  } fir_seq_state_t;

  localparam int TAPS_LP  = 1021;
  localparam int TAPS_HP  = 1021;
  localparam int Q_DEPTH  = 1536;
  localparam int Q_ADDR_W = 11;

endpackage

// File: rtl/mod_inc.sv
// rtl/mod_inc.sv - combinational pointer + OFFSET modulo DEPTH (DEPTH need not be a power of 2)
module mod_inc #(
  parameter int ADDR_W = 11,
  parameter int DEPTH  = 1536,
  parameter int OFFSET = 1
) (
  input  logic [ADDR_W-1:0] ptr,
  output logic [ADDR_W-1:0] res
);

  localparam logic [ADDR_W:0] OFF = (ADDR_W+1)'(OFFSET);
  localparam logic [ADDR_W:0] DEP = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] sum;
  logic [ADDR_W:0] sum_wrap;

  // A subtraction of k is expressed by the caller as OFFSET = DEPTH - k.
  always_comb begin
    sum      = {1'b0, ptr} + OFF;
    sum_wrap = sum - DEP;
    res      = (sum >= DEP) ? sum_wrap[ADDR_W-1:0] : sum[ADDR_W-1:0];
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR tap sequencer over a circular sample queue; FIR_SEQ_PENDING_EN adds a one-deep pending request
module fir_seq_ctrl
  import eq_pkg::*;
#(
  parameter int DEPTH  = Q_DEPTH,
  parameter int TAPS   = TAPS_LP,
  parameter int ADDR_W = Q_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrt_smpl,
  input  logic              flush,
  output logic [ADDR_W-1:0] new_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              sequencing,
  output logic              smpl_done,
  output logic              full,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(TAPS + 2);
  localparam int FILL_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TAPS + 1);
  localparam logic [CNT_W-1:0]  CNT_TAPS = CNT_W'(TAPS);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(TAPS);

  fir_seq_state_t    state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [FILL_W-1:0] fill;
  logic [ADDR_W-1:0] old_ptr, new_inc, new_sub, rd_inc;
  logic              fill_hit, pend_go;

  mod_inc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OFFSET(1)) u_new_inc (.ptr(new_ptr), .res(new_inc));
  mod_inc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OFFSET((DEPTH - (TAPS - 1)) % DEPTH))
    u_new_sub (.ptr(new_ptr), .res(new_sub));
  mod_inc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .OFFSET(1)) u_rd_inc (.ptr(rd_ptr), .res(rd_inc));

  assign full     = (fill == FILL_MAX);
  assign fill_hit = full || (fill == FILL_MAX - 1'b1);

`ifdef FIR_SEQ_PENDING_EN
  logic              pend;
  logic [ADDR_W-1:0] pend_ptr;
  // A sample arriving in DONE itself is taken as the pending request.
  assign pend_go = pend || wrt_smpl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      pend_ptr <= '0;
    end else if (flush) begin
      pend     <= 1'b0;
      pend_ptr <= '0;
    end else begin
      if (state == DONE)
        pend <= 1'b0;
      else if (state == SEQ && wrt_smpl)
        pend <= 1'b1;
      if (wrt_smpl && state != IDLE)
        pend_ptr <= new_sub;
    end
  end
`else
  assign pend_go = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == SEQ && state_nxt == SEQ) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wrt_smpl && fill_hit) state_nxt = SEQ;
      SEQ:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = pend_go ? SEQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sequencing = (state == SEQ);
    smpl_done  = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      new_ptr <= '0;
      rd_ptr  <= '0;
      old_ptr <= '0;
      fill    <= '0;
      overrun <= 1'b0;
    end else if (flush) begin
      new_ptr <= '0;
      rd_ptr  <= '0;
      old_ptr <= '0;
      fill    <= '0;
      overrun <= 1'b0;
    end else begin
      if (wrt_smpl) begin
        new_ptr <= new_inc;
        if (!full) fill <= fill + 1'b1;
      end
`ifdef FIR_SEQ_PENDING_EN
      if (state == DONE && pend_go)
        old_ptr <= wrt_smpl ? new_sub : pend_ptr;
      if (wrt_smpl && pend)
        overrun <= 1'b1;
`else
      if (wrt_smpl && state != IDLE)
        overrun <= 1'b1;
`endif
      if (state == IDLE && wrt_smpl)
        old_ptr <= new_sub;
      // rd_ptr leads the coefficient ROM by one cycle: load at c=0, step through c=TAPS-1.
      if (state == SEQ) begin
        if (cnt == '0)
          rd_ptr <= old_ptr;
        else if (cnt < CNT_TAPS)
          rd_ptr <= rd_inc;
      end
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed table-driven bench for fir_seq_ctrl (DEPTH=8, TAPS=5)
module tb_fir_seq_ctrl;

  localparam int DEPTH  = 8;
  localparam int TAPS   = 5;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              rst_n;
  logic              wrt_smpl;
  logic              flush;
  logic [ADDR_W-1:0] new_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              sequencing;
  logic              smpl_done;
  logic              full;
  logic              overrun;

  int checks;
  int errors;

  fir_seq_ctrl #(.DEPTH(DEPTH), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .wrt_smpl(wrt_smpl), .flush(flush),
    .new_ptr(new_ptr), .rd_ptr(rd_ptr), .sequencing(sequencing),
    .smpl_done(smpl_done), .full(full), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic w;
    logic f;
    int   np;
    int   rp;
    logic sq;
    logic dn;
    logic fl;
    logic ov;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic w, input logic f);
    wrt_smpl = w;
    flush    = f;
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0;
    flush    = 1'b0;
  endtask

  // Caller has just reached c=0; walks c=1..TAPS+1 and the DONE cycle.
  task automatic run_body(input int exp_old);
    for (int c = 1; c <= TAPS + 1; c++) begin
      tick(1'b0, 1'b0);
      chk($sformatf("seq_c%0d", c), int'(sequencing), 1);
      if (c <= TAPS)
        chk($sformatf("rd_c%0d", c), int'(rd_ptr), (exp_old + c - 1) % DEPTH);
      else
        chk("rd_hold", int'(rd_ptr), (exp_old + TAPS - 1) % DEPTH);
      chk("done_in_seq", int'(smpl_done), 0);
    end
    tick(1'b0, 1'b0);
    chk("seq_in_done", int'(sequencing), 0);
    chk("done_pulse", int'(smpl_done), 1);
  endtask

  task automatic seq_from_pulse(input int exp_old, input int exp_new);
    tick(1'b1, 1'b0);
    chk("new_ptr_start", int'(new_ptr), exp_new);
    chk("seq_c0", int'(sequencing), 1);
    run_body(exp_old);
    tick(1'b0, 1'b0);
    chk("done_one_cycle", int'(smpl_done), 0);
    chk("idle_after_done", int'(sequencing), 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    wrt_smpl = 1'b0;
    flush    = 1'b0;

    //            w     f     np rp sq    dn    fl    ov
    vt[0]  = '{1'b1, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 4, 0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 5, 0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 5, 1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 5, 2, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 5, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[9]  = '{1'b0, 1'b0, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[10] = '{1'b0, 1'b0, 5, 4, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[11] = '{1'b0, 1'b0, 5, 4, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[12] = '{1'b0, 1'b0, 5, 4, 1'b0, 1'b0, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_new_ptr", int'(new_ptr), 0);
    chk("rst_rd_ptr", int'(rd_ptr), 0);
    chk("rst_seq", int'(sequencing), 0);
    chk("rst_done", int'(smpl_done), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      tick(vt[i].w, vt[i].f);
      chk($sformatf("v%0d_new_ptr", i), int'(new_ptr), vt[i].np);
      chk($sformatf("v%0d_rd_ptr", i), int'(rd_ptr), vt[i].rp);
      chk($sformatf("v%0d_seq", i), int'(sequencing), int'(vt[i].sq));
      chk($sformatf("v%0d_done", i), int'(smpl_done), int'(vt[i].dn));
      chk($sformatf("v%0d_full", i), int'(full), int'(vt[i].fl));
      chk($sformatf("v%0d_overrun", i), int'(overrun), int'(vt[i].ov));
    end

    // Wrap: writes at W=5,6,7,0,1; last gives old_ptr 5 and rd 5,6,7,0,1.
    seq_from_pulse(1, 6);
    seq_from_pulse(2, 7);
    seq_from_pulse(3, 0);
    seq_from_pulse(4, 1);
    seq_from_pulse(5, 2);
    chk("wrap_overrun", int'(overrun), 0);

    // Sample arriving at c=3 of a sequence started by W=2 (old_ptr 6).
    begin
      int rd_exp[7];
      rd_exp[1] = 6; rd_exp[2] = 7; rd_exp[3] = 0;
      rd_exp[4] = 1; rd_exp[5] = 2; rd_exp[6] = 2;
      tick(1'b1, 1'b0);
      chk("c3_seq_c0", int'(sequencing), 1);
      for (int c = 1; c <= 6; c++) begin
        tick(c == 4, 1'b0);
        chk($sformatf("c3_rd_c%0d", c), int'(rd_ptr), rd_exp[c]);
        chk($sformatf("c3_seq_c%0d", c), int'(sequencing), 1);
      end
      chk("c3_new_ptr", int'(new_ptr), 4);
      tick(1'b0, 1'b0);
      chk("c3_done", int'(smpl_done), 1);
    end
`ifdef FIR_SEQ_PENDING_EN
    tick(1'b0, 1'b0);
    chk("pend_seq_restart", int'(sequencing), 1);
    chk("pend_done_clear", int'(smpl_done), 0);
    run_body(7);
    tick(1'b0, 1'b0);
    chk("pend_idle", int'(sequencing), 0);
    chk("pend_overrun", int'(overrun), 0);
`else
    chk("nopend_overrun", int'(overrun), 1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      chk("nopend_no_seq", int'(sequencing), 0);
    end
`endif

    // Flush at c=2 aborts the sequence and clears everything.
    tick(1'b1, 1'b0);
    chk("fl_seq_c0", int'(sequencing), 1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("fl_seq", int'(sequencing), 0);
    chk("fl_new_ptr", int'(new_ptr), 0);
    chk("fl_rd_ptr", int'(rd_ptr), 0);
    chk("fl_full", int'(full), 0);
    chk("fl_overrun", int'(overrun), 0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0);
      chk("fl_no_done", int'(smpl_done), 0);
    end

    // Flush wins over a simultaneous write; fill restarts from zero.
    tick(1'b1, 1'b1);
    chk("flw_new_ptr", int'(new_ptr), 0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    chk("refill_new_ptr", int'(new_ptr), 4);
    chk("refill_not_full", int'(full), 0);
    chk("refill_no_seq", int'(sequencing), 0);
    tick(1'b1, 1'b0);
    chk("refill_full", int'(full), 1);
    chk("refill_seq", int'(sequencing), 1);
    run_body(0);
    tick(1'b0, 1'b0);

    // Async reset mid-sequence.
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("pre_rst_seq", int'(sequencing), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seq", int'(sequencing), 0);
    chk("arst_new_ptr", int'(new_ptr), 0);
    chk("arst_full", int'(full), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_no_done", int'(smpl_done), 0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
    chk("arst_refill_not_full", int'(full), 0);
    chk("arst_refill_no_seq", int'(sequencing), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
